// File: rtl/csr_access_ctrl.sv
// Machine-mode CSR sequencer: Zicsr read-modify-write, trap entry and mret over one CSR file port.
// Optional macro CSR_TRAP_TVAL_EN adds the T_TVAL state so trap entry also writes mtval.
module csr_access_ctrl (
    input  logic        ctrl_clk,
    input  logic        ctrl_reset_n,
    output logic        ready,
    input  logic        req_valid,
    input  logic [2:0]  req_funct3,
    input  logic [11:0] req_addr,
    input  logic [31:0] req_rs1_data,
    input  logic [4:0]  req_uimm,
    input  logic        req_rs1_zero,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_illegal,
    input  logic        trap_valid,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_tval,
    input  logic        mret_valid,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [11:0] csr_addr,
    output logic [31:0] csr_wdata,
    output logic        csr_wen,
    input  logic [31:0] csr_rdata
);
    localparam logic [11:0] MSTATUS = 12'h300, MTVEC = 12'h305, MEPC = 12'h341,
                            MCAUSE = 12'h342, MTVAL = 12'h343;

    typedef enum logic [3:0] {
        IDLE, C_RD, C_WR, C_RESP, T_EPC, T_CAUSE, T_TVAL, T_ST_RD, T_ST_WR,
        T_VEC_RD, M_ST_RD, M_ST_WR, M_EPC_RD, REDIR
    } state_t;

    state_t      state, state_nxt;
    logic [2:0]  funct3_q;
    logic [11:0] addr_q;
    logic [31:0] rs1_q, cause_q, old_q;
    logic [4:0]  uimm_q;
    logic        rs1z_q, is_mret_q;
    logic [29:0] pc_q;
`ifdef CSR_TRAP_TVAL_EN
    logic [31:0] tval_q;
    logic [1:0]  unused_in;
    assign unused_in = trap_pc[1:0];
`else
    logic [33:0] unused_in;
    assign unused_in = {trap_pc[1:0], trap_tval};
`endif

    logic [31:0] src, wval, trap_target, vec_base;
    logic        wr_needed, addr_ok, illegal;

    assign src       = funct3_q[2] ? {27'b0, uimm_q} : rs1_q;
    assign wr_needed = (funct3_q[1:0] == 2'b01) || (funct3_q[2] ? (uimm_q != 5'd0) : !rs1z_q);

    always_comb begin
        case (addr_q)
            12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
            12'h342, 12'h343, 12'h344, 12'hF14: addr_ok = 1'b1;
            default:                           addr_ok = 1'b0;
        endcase
    end

    // Read-only space (addr[11:10] == 11) is only illegal when actually written.
    assign illegal = (funct3_q[1:0] == 2'b00) || !addr_ok ||
                     (wr_needed && addr_q[11:10] == 2'b11);

    always_comb begin
        case (funct3_q[1:0])
            2'b10:   wval = old_q | src;
            2'b11:   wval = old_q & ~src;
            default: wval = src;
        endcase
    end

    // old_q holds mtvec when REDIR is reached from trap entry.
    assign vec_base    = {old_q[31:2], 2'b00};
    assign trap_target = (old_q[1:0] == 2'b01 && cause_q[31]) ?
                         vec_base + {cause_q[29:0], 2'b00} : vec_base;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (trap_valid)      state_nxt = T_EPC;
                else if (mret_valid) state_nxt = M_ST_RD;
                else if (req_valid)  state_nxt = C_RD;
            end
            C_RD:     state_nxt = C_WR;
            C_WR:     state_nxt = C_RESP;
            T_EPC:    state_nxt = T_CAUSE;
`ifdef CSR_TRAP_TVAL_EN
            T_CAUSE:  state_nxt = T_TVAL;
            T_TVAL:   state_nxt = T_ST_RD;
`else
            T_CAUSE:  state_nxt = T_ST_RD;
`endif
            T_ST_RD:  state_nxt = T_ST_WR;
            T_ST_WR:  state_nxt = T_VEC_RD;
            T_VEC_RD: state_nxt = REDIR;
            M_ST_RD:  state_nxt = M_ST_WR;
            M_ST_WR:  state_nxt = M_EPC_RD;
            M_EPC_RD: state_nxt = REDIR;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready          = (state == IDLE);
        resp_valid     = 1'b0;
        resp_rdata     = 32'd0;
        resp_illegal   = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        csr_addr       = 12'd0;
        csr_wdata      = 32'd0;
        csr_wen        = 1'b0;
        case (state)
            C_RD: csr_addr = addr_q;
            C_WR: begin
                csr_addr  = addr_q;
                csr_wdata = wval;
                csr_wen   = wr_needed && !illegal;
            end
            C_RESP: begin
                resp_valid   = 1'b1;
                resp_rdata   = illegal ? 32'd0 : old_q;
                resp_illegal = illegal;
            end
            T_EPC:   begin csr_addr = MEPC;   csr_wdata = {pc_q, 2'b00}; csr_wen = 1'b1; end
            T_CAUSE: begin csr_addr = MCAUSE; csr_wdata = cause_q;       csr_wen = 1'b1; end
`ifdef CSR_TRAP_TVAL_EN
            T_TVAL:  begin csr_addr = MTVAL;  csr_wdata = tval_q;        csr_wen = 1'b1; end
`endif
            T_ST_RD: csr_addr = MSTATUS;
            T_ST_WR: begin
                csr_addr  = MSTATUS;
                csr_wdata = {old_q[31:8], old_q[3], old_q[6:4], 1'b0, old_q[2:0]};
                csr_wen   = 1'b1;
            end
            T_VEC_RD: csr_addr = MTVEC;
            M_ST_RD:  csr_addr = MSTATUS;
            M_ST_WR: begin
                csr_addr  = MSTATUS;
                csr_wdata = {old_q[31:8], 1'b1, old_q[6:4], old_q[7], old_q[2:0]};
                csr_wen   = 1'b1;
            end
            M_EPC_RD: csr_addr = MEPC;
            REDIR: begin
                redirect_valid = 1'b1;
                redirect_pc    = is_mret_q ? old_q : trap_target;
            end
            default: ;
        endcase
    end

    always_ff @(posedge ctrl_clk) begin
        if (!ctrl_reset_n) begin
            state     <= IDLE;
            funct3_q  <= 3'd0;
            addr_q    <= 12'd0;
            rs1_q     <= 32'd0;
            uimm_q    <= 5'd0;
            rs1z_q    <= 1'b0;
            pc_q      <= 30'd0;
            cause_q   <= 32'd0;
            is_mret_q <= 1'b0;
            old_q     <= 32'd0;
`ifdef CSR_TRAP_TVAL_EN
            tval_q    <= 32'd0;
`endif
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                if (trap_valid) begin
                    pc_q      <= trap_pc[31:2];
                    cause_q   <= trap_cause;
                    is_mret_q <= 1'b0;
`ifdef CSR_TRAP_TVAL_EN
                    tval_q    <= trap_tval;
`endif
                end else if (mret_valid) begin
                    is_mret_q <= 1'b1;
                end else if (req_valid) begin
                    funct3_q <= req_funct3;
                    addr_q   <= req_addr;
                    rs1_q    <= req_rs1_data;
                    uimm_q   <= req_uimm;
                    rs1z_q   <= req_rs1_zero;
                end
            end
            if (state == C_RD || state == T_ST_RD || state == T_VEC_RD ||
                state == M_ST_RD || state == M_EPC_RD)
                old_q <= csr_rdata;
        end
    end
endmodule

// File: tb/tb_csr_access_ctrl.sv
// Directed bench for csr_access_ctrl with a behavioural CSR file and write log.
module tb_csr_access_ctrl;
    logic        ctrl_clk = 1'b0;
    logic        ctrl_reset_n = 1'b0;
    logic        ready;
    logic        req_valid = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [11:0] req_addr = 12'd0;
    logic [31:0] req_rs1_data = 32'd0;
    logic [4:0]  req_uimm = 5'd0;
    logic        req_rs1_zero = 1'b0;
    logic        resp_valid, resp_illegal;
    logic [31:0] resp_rdata;
    logic        trap_valid = 1'b0;
    logic [31:0] trap_pc = 32'd0, trap_cause = 32'd0, trap_tval = 32'd0;
    logic        mret_valid = 1'b0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata, csr_rdata;
    logic        csr_wen;

`ifdef CSR_TRAP_TVAL_EN
    localparam int TLAT = 7;
`else
    localparam int TLAT = 6;
`endif

    csr_access_ctrl dut (
        .ctrl_clk(ctrl_clk), .ctrl_reset_n(ctrl_reset_n), .ready(ready),
        .req_valid(req_valid), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_rs1_data(req_rs1_data), .req_uimm(req_uimm), .req_rs1_zero(req_rs1_zero),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_illegal(resp_illegal),
        .trap_valid(trap_valid), .trap_pc(trap_pc), .trap_cause(trap_cause),
        .trap_tval(trap_tval), .mret_valid(mret_valid), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .csr_wen(csr_wen), .csr_rdata(csr_rdata)
    );

    always #5 ctrl_clk = ~ctrl_clk;

    // CSR file model: combinational read, write on posedge, plus a preload port for the bench.
    logic [31:0] mem [0:4095];
    logic [43:0] wlog [$];
    logic        pl_en = 1'b0;
    logic [11:0] pl_addr = 12'd0;
    logic [31:0] pl_data = 32'd0;
    assign csr_rdata = mem[csr_addr];
    always @(posedge ctrl_clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        if (csr_wen) begin
            mem[csr_addr] <= csr_wdata;
            wlog.push_back({csr_addr, csr_wdata});
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        pl_addr = a; pl_data = d; pl_en = 1'b1;
        @(posedge ctrl_clk);
        @(negedge ctrl_clk);
        pl_en = 1'b0;
    endtask

    task automatic wait_ready();
        bit ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (ready) begin ok = 1; break; end
            @(negedge ctrl_clk);
        end
        if (!ok) chk("ready_timeout", 0, 1);
    endtask

    // Called at the negedge of cycle N+1; lat is the cycle index k of the pulse (N+k).
    task automatic wait_pulse(input bit redir, output int lat, output logic [31:0] d,
                              output logic ill);
        lat = -1; d = 32'd0; ill = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (redir ? redirect_valid : resp_valid) begin
                lat = k;
                d   = redir ? redirect_pc : resp_rdata;
                ill = resp_illegal;
                break;
            end
            @(negedge ctrl_clk);
        end
        if (lat < 0) begin
            chk("pulse_timeout", 0, 1);
        end else begin
            @(negedge ctrl_clk);
            chk("pulse_width", redir ? redirect_valid : resp_valid, 0);
            chk("ready_after", ready, 1);
        end
    endtask

    task automatic do_csr(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] rs1,
                          input logic [4:0] ui, input logic rz, output int lat,
                          output logic [31:0] rd, output logic ill, output int ws);
        wait_ready();
        ws = wlog.size();
        req_funct3 = f3; req_addr = a; req_rs1_data = rs1; req_uimm = ui; req_rs1_zero = rz;
        req_valid = 1'b1;
        @(negedge ctrl_clk);
        req_valid = 1'b0;
        req_rs1_data = 32'hFFFF_FFFF; req_uimm = 5'h1F; req_addr = 12'h000;
        wait_pulse(0, lat, rd, ill);
    endtask

    task automatic do_trap(input logic [31:0] pc, input logic [31:0] cause,
                           input logic [31:0] tval, output int lat, output logic [31:0] npc,
                           output int ws);
        logic ill;
        wait_ready();
        ws = wlog.size();
        trap_pc = pc; trap_cause = cause; trap_tval = tval; trap_valid = 1'b1;
        @(negedge ctrl_clk);
        trap_valid = 1'b0; trap_pc = 32'hFFFF_FFFF; trap_cause = 32'd0;
        wait_pulse(1, lat, npc, ill);
    endtask

    task automatic chk_wr(input string tag, input int idx, input logic [11:0] a,
                          input logic [31:0] d);
        logic [43:0] e;
        e = (idx < wlog.size()) ? wlog[idx] : 44'hFFF_FFFF_FFFF;
        chk(tag, e, {a, d});
    endtask

    int lat, ws, nord;
    logic [31:0] rd;
    logic ill, prev_ready;
    int order [3];

    initial begin
        // Reset state
        repeat (3) @(negedge ctrl_clk);
        chk("rst_ready", ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_redirect_valid", redirect_valid, 0);
        chk("rst_csr_wen", csr_wen, 0);
        chk("rst_csr_addr", csr_addr, 0);
        chk("rst_csr_wdata", csr_wdata, 0);
        ctrl_reset_n = 1'b1;
        @(negedge ctrl_clk);

        // CSRRS mscratch
        preload(12'h340, 32'h0000_00F0);
        do_csr(3'b010, 12'h340, 32'h0F, 5'd0, 1'b0, lat, rd, ill, ws);
        chk("rs_lat", lat, 3);
        chk("rs_rdata", rd, 32'hF0);
        chk("rs_ill", ill, 0);
        chk("rs_nwr", wlog.size() - ws, 1);
        chk_wr("rs_wr", ws, 12'h340, 32'hFF);
        // CSRRS with rs1 = x0: read only
        do_csr(3'b010, 12'h340, 32'h0F, 5'd0, 1'b1, lat, rd, ill, ws);
        chk("rs0_lat", lat, 3);
        chk("rs0_rdata", rd, 32'hFF);
        chk("rs0_nwr", wlog.size() - ws, 0);

        // CSRRCI mstatus
        preload(12'h300, 32'h88);
        do_csr(3'b111, 12'h300, 32'h0, 5'd8, 1'b0, lat, rd, ill, ws);
        chk("rci_rdata", rd, 32'h88);
        chk("rci_nwr", wlog.size() - ws, 1);
        chk_wr("rci_wr", ws, 12'h300, 32'h80);

        // Illegal and read-only boundaries
        preload(12'hF14, 32'h5);
        do_csr(3'b001, 12'hF14, 32'h1234, 5'd0, 1'b0, lat, rd, ill, ws);
        chk("rw_ro_lat", lat, 3);
        chk("rw_ro_ill", ill, 1);
        chk("rw_ro_rdata", rd, 0);
        chk("rw_ro_nwr", wlog.size() - ws, 0);
        do_csr(3'b010, 12'hF14, 32'h1234, 5'd0, 1'b1, lat, rd, ill, ws);
        chk("rs_ro_ill", ill, 0);
        chk("rs_ro_rdata", rd, 32'h5);
        do_csr(3'b000, 12'h340, 32'h1, 5'd0, 1'b0, lat, rd, ill, ws);
        chk("f3_0_ill", ill, 1);
        chk("f3_0_nwr", wlog.size() - ws, 0);
        do_csr(3'b110, 12'h345, 32'h0, 5'd3, 1'b0, lat, rd, ill, ws);
        chk("addr_345_ill", ill, 1);
        chk("addr_345_nwr", wlog.size() - ws, 0);

        // Trap entry, vectored interrupt
        preload(12'h305, 32'h1001);
        preload(12'h300, 32'h08);
        preload(12'h343, 32'hDEAD);
        do_trap(32'h203, 32'h8000_0007, 32'h1234, lat, rd, ws);
        chk("trap_lat", lat, TLAT);
        chk("trap_pc", rd, 32'h101C);
        chk("trap_nwr", wlog.size() - ws, TLAT - 3);
        chk_wr("trap_mepc", ws, 12'h341, 32'h200);
        chk_wr("trap_mcause", ws + 1, 12'h342, 32'h8000_0007);
`ifdef CSR_TRAP_TVAL_EN
        chk_wr("trap_mtval", ws + 2, 12'h343, 32'h1234);
        chk_wr("trap_mstatus", ws + 3, 12'h300, 32'h80);
`else
        chk_wr("trap_mstatus", ws + 2, 12'h300, 32'h80);
        chk("trap_mtval_kept", mem[12'h343], 32'hDEAD);
`endif
        // Exception (cause bit 31 clear) on vectored mtvec goes to base
        do_trap(32'h500, 32'h0000_0002, 32'h0, lat, rd, ws);
        chk("exc_pc", rd, 32'h1000);

        // mret
        preload(12'h300, 32'h80);
        preload(12'h341, 32'h400);
        wait_ready();
        ws = wlog.size();
        mret_valid = 1'b1;
        @(negedge ctrl_clk);
        mret_valid = 1'b0;
        wait_pulse(1, lat, rd, ill);
        chk("mret_lat", lat, 4);
        chk("mret_pc", rd, 32'h400);
        chk("mret_nwr", wlog.size() - ws, 1);
        chk_wr("mret_mstatus", ws, 12'h300, 32'h88);

        // Simultaneous requests: identify each winner by its first port access
        wait_ready();
        req_funct3 = 3'b010; req_addr = 12'h340; req_rs1_zero = 1'b1;
        trap_pc = 32'h100; trap_cause = 32'h3;
        trap_valid = 1'b1; mret_valid = 1'b1; req_valid = 1'b1;
        nord = 0; prev_ready = 1'b1;
        for (int i = 0; i < 80 && nord < 3; i++) begin
            @(negedge ctrl_clk);
            if (prev_ready && !ready) begin
                if (csr_addr == 12'h341 && csr_wen) begin order[nord] = 1; trap_valid = 1'b0; end
                else if (csr_addr == 12'h300 && !csr_wen) begin order[nord] = 2; mret_valid = 1'b0; end
                else if (csr_addr == 12'h340) begin order[nord] = 3; req_valid = 1'b0; end
                else order[nord] = 0;
                nord++;
            end
            prev_ready = ready;
        end
        trap_valid = 1'b0; mret_valid = 1'b0; req_valid = 1'b0;
        chk("prio_count", nord, 3);
        chk("prio_first_trap", order[0], 1);
        chk("prio_second_mret", order[1], 2);
        chk("prio_third_csr", order[2], 3);

        // Reset during T_ST_RD
        preload(12'h300, 32'h08);
        wait_ready();
        ws = wlog.size();
        trap_pc = 32'h700; trap_cause = 32'h8000_0003; trap_valid = 1'b1;
        @(negedge ctrl_clk);
        trap_valid = 1'b0;
        repeat (TLAT - 4) @(negedge ctrl_clk);
        chk("rst_mid_in_strd", {csr_addr, csr_wen}, {12'h300, 1'b0});
        ctrl_reset_n = 1'b0;
        @(negedge ctrl_clk);
        chk("rst_mid_ready", ready, 1);
        chk("rst_mid_outs", {resp_valid, resp_rdata, resp_illegal, redirect_valid,
                             redirect_pc, csr_addr, csr_wdata, csr_wen}, 0);
        ctrl_reset_n = 1'b1;
        repeat (6) @(negedge ctrl_clk);
        chk("rst_mid_nwr", wlog.size() - ws, TLAT - 4);
        chk("rst_mid_mstatus", mem[12'h300], 32'h08);
        chk("rst_mid_idle", ready, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
